// File: rtl/exec_pkg.sv
// Shared types and constants for the execute/writeback stage.
// The multiplier path is enabled by the EXEC_MUL_EN macro in the files that import this package.
package exec_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam int MUL_ITERS = 8;
    localparam int SHAMT_W   = 3;

endpackage

// File: rtl/mul8_seq.sv
// Sequential shift-add multiplier: one multiplier bit per cycle after load.
// Compiled only when EXEC_MUL_EN is defined.
`ifdef EXEC_MUL_EN
module mul8_seq
    import exec_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic           last
);

    localparam int CW = $clog2(MUL_ITERS) + 1;

    logic           active_q, active_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load) begin
            active_d = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, a};
            mplier_d = b;
        end else if (active_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(MUL_ITERS - 1)) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    // Final iteration happens on the edge that ends this cycle.
    assign last    = active_q && (cnt_q == CW'(MUL_ITERS - 1));
    assign product = acc_q;

endmodule
`endif

// File: rtl/exec_unit.sv
// Single-issue execute/writeback stage: ALU ops in one EXEC cycle, MUL via mul8_seq.
// Multiplier support is compiled in only when EXEC_MUL_EN is defined.
module exec_unit
    import exec_pkg::*;
#(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [AW-1:0] rd_sel,
    input  logic [AW-1:0] rs_sel,
    input  logic [W-1:0]  a_in,
    input  logic [W-1:0]  b_in,
    output logic [AW-1:0] rd,
    output logic [AW-1:0] rs,
    output logic          reg_write,
    output logic [W-1:0]  data_out,
    output logic          busy,
    output logic          done,
    output logic          flag_z,
    output logic          flag_c
);

    state_t        state_q, state_d;
    op_t           op_q, op_d;
    logic [AW-1:0] rd_q, rd_d, rs_q, rs_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [W-1:0]  res_q, res_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  data_out_q, data_out_d;
    logic          flag_z_q, flag_z_d, flag_c_q, flag_c_d;

    logic [W-1:0]  alu_res;
    logic          alu_c;
    logic [W-1:0]  wb_result;
    logic          wb_carry;
    logic          wb_valid;

    logic [W:0]         sum, diff, sh_l, sh_r;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = b_q[SHAMT_W-1:0];
    assign sum   = {1'b0, a_q} + {1'b0, b_q};
    assign diff  = {1'b0, a_q} - {1'b0, b_q};
    // One spare bit catches the last bit shifted out; a zero shift leaves it 0.
    assign sh_l  = {1'b0, a_q} << shamt;
    assign sh_r  = {a_q, 1'b0} >> shamt;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            OP_ADD: begin alu_res = sum[W-1:0];  alu_c = sum[W];  end
            OP_SUB: begin alu_res = diff[W-1:0]; alu_c = diff[W]; end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin alu_res = sh_l[W-1:0]; alu_c = sh_l[W]; end
            OP_SHR: begin alu_res = sh_r[W:1];   alu_c = sh_r[0]; end
            default: begin alu_res = '0; alu_c = 1'b0; end
        endcase
    end

`ifdef EXEC_MUL_EN
    logic [2*W-1:0] mul_product;
    logic           mul_last;
    logic           mul_load;

    assign mul_load = (state_q == S_IDLE) && start && (op_t'(op) == OP_MUL);

    mul8_seq #(.W(W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (mul_load),
        .a       (a_in),
        .b       (b_in),
        .product (mul_product),
        .last    (mul_last)
    );

    assign wb_valid  = 1'b1;
    assign wb_result = (op_q == OP_MUL) ? mul_product[W-1:0] : res_q;
    assign wb_carry  = (op_q == OP_MUL) ? (|mul_product[2*W-1:W]) : carry_q;
`else
    assign wb_valid  = (op_q != OP_MUL);
    assign wb_result = res_q;
    assign wb_carry  = carry_q;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        rs_d       = rs_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        carry_d    = carry_q;
        data_out_d = data_out_q;
        flag_z_d   = flag_z_q;
        flag_c_d   = flag_c_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op_t'(op);
                    rd_d    = rd_sel;
                    rs_d    = rs_sel;
                    a_d     = a_in;
                    b_d     = b_in;
                    state_d = S_EXEC;
`ifdef EXEC_MUL_EN
                    if (op_t'(op) == OP_MUL) state_d = S_MUL;
`endif
                end
            end
            S_EXEC: begin
                res_d   = alu_res;
                carry_d = alu_c;
                state_d = S_WB;
            end
`ifdef EXEC_MUL_EN
            S_MUL: begin
                if (mul_last) state_d = S_WB;
            end
`endif
            S_WB: begin
                state_d = S_IDLE;
                if (wb_valid) begin
                    data_out_d = wb_result;
                    flag_z_d   = (wb_result == '0);
                    flag_c_d   = wb_carry;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_ADD;
            rd_q       <= '0;
            rs_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            data_out_q <= '0;
            flag_z_q   <= 1'b0;
            flag_c_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rs_q       <= rs_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            data_out_q <= data_out_d;
            flag_z_q   <= flag_z_d;
            flag_c_q   <= flag_c_d;
        end
    end

    assign rd        = (state_q == S_IDLE) ? rd_sel : rd_q;
    assign rs        = (state_q == S_IDLE) ? rs_sel : rs_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_WB);
    assign reg_write = (state_q == S_WB) && wb_valid;
    // In WB the next-value already equals the result; elsewhere it is the held value.
    assign data_out  = data_out_d;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit with a behavioural register file.
// Covers the multiplier path when EXEC_MUL_EN is defined, the disabled-opcode path otherwise.
module tb_exec_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [2:0] rd_sel, rs_sel;
    logic [7:0] a_in, b_in;
    logic [2:0] rd, rs;
    logic       reg_write;
    logic [7:0] data_out;
    logic       busy, done, flag_z, flag_c;

    logic [7:0] regs [8];
    logic       pre_we;
    logic [2:0] pre_addr;
    logic [7:0] pre_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    exec_unit #(.W(8), .AW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rd_sel    (rd_sel),
        .rs_sel    (rs_sel),
        .a_in      (a_in),
        .b_in      (b_in),
        .rd        (rd),
        .rs        (rs),
        .reg_write (reg_write),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    assign a_in = regs[rd];
    assign b_in = regs[rs];

    always @(posedge clk) begin
        if (reg_write)   regs[rd]       <= data_out;
        else if (pre_we) regs[pre_addr] <= pre_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] addr, input logic [7:0] val);
        pre_we = 1'b1; pre_addr = addr; pre_data = val;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issue one op from a negedge in IDLE, wait for done, check WB and the cycle after.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [2:0] d,
                          input logic [2:0] s, input logic [7:0] ed, input logic ez,
                          input logic ec, input int elat, input logic ewe);
        int cyc;
        start = 1'b1; op = o; rd_sel = d; rs_sel = s;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            chk({tag, " busy"}, busy, 1'b1);
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, cyc, elat);
        chk({tag, " reg_write"}, reg_write, ewe);
        chk({tag, " wb rd"}, rd, d);
        if (ewe) chk({tag, " data_out"}, data_out, ed);
        @(negedge clk);
        chk({tag, " busy after"}, busy, 1'b0);
        chk({tag, " done after"}, done, 1'b0);
        chk({tag, " flag_z"}, flag_z, ez);
        chk({tag, " flag_c"}, flag_c, ec);
        chk({tag, " regfile"}, regs[d], ed);
    endtask

    initial begin
        int pulses;
        logic [2:0] wr_rd;
        logic [7:0] wr_data;

        reset = 1'b0; start = 1'b0; op = 3'd0; rd_sel = 3'd5; rs_sel = 3'd2;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", busy, 1'b0);
        chk("rst reg_write", reg_write, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst data_out", data_out, 8'd0);
        chk("rst flag_z", flag_z, 1'b0);
        chk("rst flag_c", flag_c, 1'b0);
        chk("idle rd mux", rd, 3'd5);
        chk("idle rs mux", rs, 3'd2);
        reset = 1'b1;
        @(negedge clk);

        preload(3'd0, 8'd200); preload(3'd1, 8'd100);
        run_op("add", 3'd0, 3'd0, 3'd1, 8'd44, 1'b0, 1'b1, 1, 1'b1);
        chk("data_out hold", data_out, 8'd44);

        preload(3'd2, 8'd5); preload(3'd3, 8'd7);
        run_op("sub borrow", 3'd1, 3'd2, 3'd3, 8'd254, 1'b0, 1'b1, 1, 1'b1);
        run_op("sub same reg", 3'd1, 3'd3, 3'd3, 8'd0, 1'b1, 1'b0, 1, 1'b1);

        preload(3'd4, 8'h81); preload(3'd5, 8'd1);
        run_op("shl", 3'd5, 3'd4, 3'd5, 8'h02, 1'b0, 1'b1, 1, 1'b1);
        preload(3'd4, 8'h81); preload(3'd6, 8'd0);
        run_op("shr0", 3'd6, 3'd4, 3'd6, 8'h81, 1'b0, 1'b0, 1, 1'b1);
        run_op("xor self", 3'd4, 3'd4, 3'd4, 8'h00, 1'b1, 1'b0, 1, 1'b1);
        preload(3'd4, 8'h81); preload(3'd5, 8'd3);
        run_op("shr3", 3'd6, 3'd4, 3'd5, 8'h10, 1'b0, 1'b0, 1, 1'b1);

        reset = 1'b0; start = 1'b1; op = 3'd0; rd_sel = 3'd0; rs_sel = 3'd1;
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        chk("start+reset busy", busy, 1'b0);
        @(negedge clk);
        chk("start+reset done", done, 1'b0);
        chk("start+reset r0", regs[0], 8'd44);

`ifdef EXEC_MUL_EN
        preload(3'd7, 8'd13); preload(3'd1, 8'd11);
        run_op("mul 13x11", 3'd7, 3'd7, 3'd1, 8'd143, 1'b0, 1'b0, 8, 1'b1);
        preload(3'd6, 8'd16); preload(3'd5, 8'd16);
        run_op("mul 16x16", 3'd7, 3'd6, 3'd5, 8'd0, 1'b1, 1'b1, 8, 1'b1);

        start = 1'b1; op = 3'd7; rd_sel = 3'd7; rs_sel = 3'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mulrst busy", busy, 1'b0);
        chk("mulrst reg_write", reg_write, 1'b0);
        chk("mulrst done", done, 1'b0);
        chk("mulrst flag_z", flag_z, 1'b0);
        chk("mulrst flag_c", flag_c, 1'b0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (reg_write === 1'b1 || done === 1'b1) pulses++;
            @(negedge clk);
        end
        chk("mulrst no wb", pulses, 0);
        chk("mulrst r7", regs[7], 8'd143);

        preload(3'd2, 8'd3); preload(3'd3, 8'd5);
        start = 1'b1; op = 3'd7; rd_sel = 3'd2; rs_sel = 3'd3;
        @(negedge clk);
        op = 3'd0; rd_sel = 3'd0; rs_sel = 3'd1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; wr_rd = '0; wr_data = '0;
        for (int i = 0; i < 12; i++) begin
            if (reg_write === 1'b1) begin
                pulses++; wr_rd = rd; wr_data = data_out;
            end
            @(negedge clk);
        end
        chk("ignore pulses", pulses, 1);
        chk("ignore dest", wr_rd, 3'd2);
        chk("ignore data", wr_data, 8'd15);
        chk("ignore r0", regs[0], 8'd44);
        chk("ignore busy", busy, 1'b0);
`else
        start = 1'b1; op = 3'd0; rd_sel = 3'd0; rs_sel = 3'd1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("execrst busy", busy, 1'b0);
        chk("execrst reg_write", reg_write, 1'b0);
        chk("execrst done", done, 1'b0);
        chk("execrst flag_c", flag_c, 1'b0);
        @(negedge clk);
        chk("execrst r0", regs[0], 8'd44);

        run_op("xor self2", 3'd4, 3'd4, 3'd4, 8'h00, 1'b1, 1'b0, 1, 1'b1);
        preload(3'd7, 8'd13); preload(3'd1, 8'd11);
        run_op("mul disabled", 3'd7, 3'd7, 3'd1, 8'd13, 1'b1, 1'b0, 1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
# exec_unit

Single-issue execute/writeback stage for the 8-register, 8-bit datapath. Drives the register file's read addresses, latches the two operands it returns, computes an ALU or multi-cycle multiply result, and writes it back through the register file write port. Also maintains zero/carry flags for downstream branch logic.

## Interface
Parameters:
- `W`, default 8: data width; register file word width.
- `AW`, default 3: register address width (8 registers).

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-low reset (0 = reset).
- `start`, input, 1: issue request; accepted only while `busy`=0.
- `op`, input, 3: operation code, sampled with `start`.
- `rd_sel`, input, AW: destination (also operand A) register, sampled with `start`.
- `rs_sel`, input, AW: operand B register, sampled with `start`.
- `a_in`, input, W: register file `out_rd`.
- `b_in`, input, W: register file `out_rs`.
- `rd`, output, AW: register file `rd` address.
- `rs`, output, AW: register file `rs` address.
- `reg_write`, output, 1: register file write enable; one-cycle pulse.
- `data_out`, output, W: register file `data_in`.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse marking operation completion.
- `flag_z`, output, 1: zero flag.
- `flag_c`, output, 1: carry/borrow/overflow flag.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
- Address muxing: in IDLE, `rd`=`rd_sel` and `rs`=`rs_sel`, both combinational. In all other states they equal the latched addresses.
- Issue: in IDLE with `start`=1, latch `op`, the addresses, `a_in` and `b_in`. `start` is ignored while `busy`=1.
- FSM states: IDLE, EXEC, MUL, WB.
  - IDLE→EXEC when `start` and `op`≠MUL.
  - IDLE→MUL when `start` and `op`=MUL.
  - EXEC→WB after 1 cycle.
  - MUL→WB after 8 iterations.
  - WB→IDLE unconditionally.
- ADD: result = a+b mod 256; C = bit 8 of the sum.
- SUB: result = a−b mod 256; C = 1 if a<b (borrow).
- AND, OR, XOR: C = 0.
- SHL, SHR: shift amount = b[2:0].
  - C = last bit shifted out.
  - A shift of 0 gives C = 0.
  - SHR is logical (zero fill).
- MUL: shift-add over 8 cycles, one multiplier bit per cycle, into a 16-bit accumulator.
  - result = low byte.
  - C = 1 if the high byte is nonzero.
- Z = (result == 0) for all ops.
- In WB: `reg_write`=1, `data_out`=result, `done`=1. Flags update on the WB→IDLE edge.
- `data_out` holds its last value outside WB. It is 0 after reset.

## Timing
- Edge E0: `start` sampled.
- Non-MUL ops:
  - EXEC occupies the cycle E0–E1.
  - WB occupies the cycle E1–E2.
  - The register file captures the result at E2.
  - Next `start` can be accepted at E2.
- MUL:
  - MUL state occupies the cycles E0–E8.
  - WB occupies the cycle E8–E9.
  - The register file write happens at E9.
- Reset values (reset sampled 0):
  - State: IDLE.
  - `reg_write`, `done`, `busy`: 0.
  - `data_out`, `flag_z`, `flag_c`: 0.
  - Multiply counter and accumulator: 0.
- Reset mid-operation (any state): return to IDLE at that edge. No `reg_write`, no `done`, flags cleared.
- `start` and reset in the same cycle: reset wins; the request is dropped.
- `rd_sel`=`rs_sel` is legal: both operands come from the same register.

## Configuration
- Macro `EXEC_MUL_EN`, defined: MUL state, multiply counter and `mul8_seq` are compiled in; opcode 7 behaves as described.
- Macro not defined:
  - Opcode 7 takes IDLE→EXEC→WB.
  - In WB, `done`=1 but `reg_write`=0.
  - Flags unchanged.
  - No multiplier logic is present.

## Structure
- Package `exec_pkg` holds:
  - `op_t` enum with the opcode encodings above.
  - `state_t` enum (IDLE, EXEC, MUL, WB).
  - Constants `MUL_ITERS`=8 and `SHAMT_W`=3.
- Sub-module `mul8_seq`: the sequential shift-add multiplier, compiled only under `EXEC_MUL_EN`.
  - Inputs: `clk`, `reset`, `load`, `a`, `b`.
  - Outputs: 16-bit `product` and `last`.

## Test plan
- ADD, a=200, b=100: `reg_write` high in the cycle E1–E2, `data_out`=44, Z=0, C=1; register reads back 44.
- SUB, a=5, b=7: `data_out`=254, C=1. Then SUB, a=7, b=7: `data_out`=0, Z=1, C=0.
- SHL, a=0x81, b=1: `data_out`=0x02, C=1. Then SHR, a=0x81, b=0: `data_out`=0x81, C=0.
- MUL 13×11: `busy` high for 9 cycles, `reg_write` in the cycle E8–E9, `data_out`=143, C=0. Then MUL 16×16: `data_out`=0, Z=1, C=1.
- Second `start` issued at E1 during a MUL: ignored. Only one `reg_write` pulse, with the original destination.
- Reset asserted during the MUL cycle E4–E5: `busy`=0 next cycle, no `reg_write`, no `done`, flags 0.
- Build without `EXEC_MUL_EN`, issue MUL: `done` pulses in the cycle E1–E2, `reg_write` stays 0, destination register unchanged.
